vram_scheduler: RTL and testbench

Single-port VRAM arbiter and sequencer for the Specialist display subsystem. It shares one 16-bit-wide synchronous VRAM ({color, pixels}, 12K words) between three requesters:

- the video fetch engine (highest priority, fixed latency);
- the CPU bus (read and write, req/ack handshake);
- a hardware screen-fill engine (lowest priority, background).

It sits between the CPU bus decode, the video timing generator and the VRAM macro.

---
 rtl/vram_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_vram_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_scheduler.sv
// Single-port VRAM arbiter: video fetch > CPU access > background screen fill.
// One grant per clock; all VRAM-side outputs are registered.
module vram_scheduler #(
  parameter int unsigned WORDS    = 12288,
  parameter logic [15:0] WIN_BASE = 16'h9000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [13:0] vid_addr,
  output logic [15:0] vid_data,
  output logic        vid_valid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic [7:0]  cpu_color,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  input  logic        fill_start,
  input  logic [7:0]  fill_color,
  output logic        fill_busy,
  output logic [13:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata
);

  localparam logic [13:0] LastAddr = 14'(WORDS - 1);
  localparam logic [13:0] WinOff   = WIN_BASE[13:0];

  typedef enum logic [1:0] {CIdle, CPend, CWait, CDone} cpu_state_e;

  cpu_state_e  cpu_state_q, cpu_state_d;
  logic        cpu_we_q, cpu_oow_q, cpu_hold_q, cpu_hold_d, cpu_latch;
  logic [13:0] cpu_addr_q;
  logic [7:0]  cpu_din_q, cpu_color_q, cpu_dout_q, cpu_dout_d;
  logic        cpu_ack_q, cpu_ack_d, in_win;

  logic        vid_pend_q, vid_pend_d, vid_s1_q, vid_s2_q, vid_valid_q;
  logic [13:0] vid_addr_q, vid_addr_d;
  logic [15:0] vid_data_q, vid_data_d;

  logic        fill_busy_q, fill_busy_d;
  logic [13:0] fill_cnt_q, fill_cnt_d;
  logic [7:0]  fill_color_q, fill_color_d;

  logic        mem_we_q, mem_we_d;
  logic [13:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;

  logic        vid_gnt, cpu_gnt, fill_gnt;

  assign in_win = (cpu_addr[15:14] == 2'b10) && (cpu_addr[13:12] != 2'b00);

  // A strobe landing on a still-pending fetch replaces it, so hold the grant one clock.
  assign vid_gnt  = vid_pend_q & ~vid_req;
  assign cpu_gnt  = ~vid_gnt & (cpu_state_q == CPend);
  assign fill_gnt = ~vid_gnt & ~cpu_gnt & fill_busy_q;

  always_comb begin
    cpu_state_d = cpu_state_q;
    cpu_hold_d  = 1'b0;
    cpu_ack_d   = 1'b0;
    cpu_dout_d  = cpu_dout_q;
    cpu_latch   = 1'b0;
    unique case (cpu_state_q)
      CIdle: begin
        if (cpu_req && !cpu_hold_q) begin
          cpu_latch   = 1'b1;
          cpu_state_d = in_win ? CPend : CDone;
        end
      end
      CPend: if (cpu_gnt) cpu_state_d = CWait;
      CWait: cpu_state_d = CDone;
      CDone: begin
        cpu_ack_d = 1'b1;
        if (cpu_oow_q)     cpu_dout_d = 8'hFF;
        else if (!cpu_we_q) cpu_dout_d = mem_rdata[7:0];
        // Skip one sample of cpu_req so a request still held during ack is not re-served.
        cpu_hold_d  = 1'b1;
        cpu_state_d = CIdle;
      end
      default: cpu_state_d = CIdle;
    endcase
  end

  always_comb begin
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (vid_gnt) begin
      mem_addr_d = vid_addr_q;
    end else if (cpu_gnt) begin
      mem_addr_d = cpu_addr_q;
      mem_we_d   = cpu_we_q;
      if (cpu_we_q) mem_wdata_d = {cpu_color_q, cpu_din_q};
    end else if (fill_gnt) begin
      mem_addr_d  = fill_cnt_q;
      mem_we_d    = 1'b1;
      mem_wdata_d = {fill_color_q, 8'h00};
    end
  end

  always_comb begin
    fill_busy_d  = fill_busy_q;
    fill_cnt_d   = fill_cnt_q;
    fill_color_d = fill_color_q;
    if (!fill_busy_q && fill_start) begin
      fill_busy_d  = 1'b1;
      fill_cnt_d   = '0;
      fill_color_d = fill_color;
    end else if (fill_gnt) begin
      if (fill_cnt_q == LastAddr) begin
        fill_busy_d = 1'b0;
        fill_cnt_d  = '0;
      end else begin
        fill_cnt_d = fill_cnt_q + 14'd1;
      end
    end
  end

  always_comb begin
    vid_pend_d = vid_req | (vid_pend_q & ~vid_gnt);
    vid_addr_d = vid_req ? vid_addr : vid_addr_q;
    vid_data_d = vid_s2_q ? mem_rdata : vid_data_q;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cpu_state_q  <= CIdle;
      cpu_we_q     <= 1'b0;
      cpu_oow_q    <= 1'b0;
      cpu_hold_q   <= 1'b0;
      cpu_addr_q   <= '0;
      cpu_din_q    <= '0;
      cpu_color_q  <= '0;
      cpu_dout_q   <= '0;
      cpu_ack_q    <= 1'b0;
      vid_pend_q   <= 1'b0;
      vid_addr_q   <= '0;
      vid_s1_q     <= 1'b0;
      vid_s2_q     <= 1'b0;
      vid_valid_q  <= 1'b0;
      vid_data_q   <= '0;
      fill_busy_q  <= 1'b0;
      fill_cnt_q   <= '0;
      fill_color_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      cpu_state_q  <= cpu_state_d;
      cpu_hold_q   <= cpu_hold_d;
      cpu_dout_q   <= cpu_dout_d;
      cpu_ack_q    <= cpu_ack_d;
      if (cpu_latch) begin
        cpu_we_q    <= cpu_we;
        cpu_oow_q   <= ~in_win;
        cpu_addr_q  <= cpu_addr[13:0] - WinOff;
        cpu_din_q   <= cpu_din;
        cpu_color_q <= cpu_color;
      end
      vid_pend_q   <= vid_pend_d;
      vid_addr_q   <= vid_addr_d;
      vid_s1_q     <= vid_gnt;
      vid_s2_q     <= vid_s1_q;
      vid_valid_q  <= vid_s2_q;
      vid_data_q   <= vid_data_d;
      fill_busy_q  <= fill_busy_d;
      fill_cnt_q   <= fill_cnt_d;
      fill_color_q <= fill_color_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign vid_data  = vid_data_q;
  assign vid_valid = vid_valid_q;
  assign cpu_dout  = cpu_dout_q;
  assign cpu_ack   = cpu_ack_q;
  assign fill_busy = fill_busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_vram_scheduler.sv
// Directed bench for vram_scheduler with a synchronous VRAM model and
// scoreboard queues for video fetches and CPU completions.
module tb_vram_scheduler;

  localparam int unsigned WORDS = 12288;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        vid_req, cpu_req, cpu_we, fill_start, vid_valid, cpu_ack, fill_busy, mem_we;
  logic [13:0] vid_addr, mem_addr;
  logic [15:0] vid_data, cpu_addr, mem_wdata, mem_rdata;
  logic [7:0]  cpu_din, cpu_color, cpu_dout, fill_color;

  logic [15:0] vram [WORDS];

  typedef struct packed {logic [15:0] data; int due;} vid_exp_t;
  typedef struct packed {logic chk; logic [7:0] dout;} cpu_exp_t;
  vid_exp_t vid_q[$];
  cpu_exp_t cpu_q[$];

  int          cyc = 0;
  int          n_pass = 0, n_total = 0, n_fail = 0;
  int          wr_cnt = 0;
  logic [13:0] last_wa = '0;
  logic [15:0] last_wd = '0;

  vram_scheduler #(.WORDS(WORDS), .WIN_BASE(16'h9000)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data),
    .vid_valid (vid_valid),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_color (cpu_color),
    .cpu_dout  (cpu_dout),
    .cpu_ack   (cpu_ack),
    .fill_start(fill_start),
    .fill_color(fill_color),
    .fill_busy (fill_busy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    cyc <= cyc + 1;
    if (mem_we && (32'(mem_addr) < WORDS)) vram[mem_addr] <= mem_wdata;
    if (32'(mem_addr) < WORDS) mem_rdata <= vram[mem_addr];
    else mem_rdata <= 16'h0000;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: pops scoreboard entries when the DUT completes a transaction.
  initial begin
    vid_exp_t ve;
    cpu_exp_t ce;
    forever begin
      @(negedge clk_sys);
      if (!reset) begin
        if (vid_valid) begin
          chk("vid_expected", 32'(vid_q.size() != 0), 1);
          if (vid_q.size() != 0) begin
            ve = vid_q.pop_front();
            chk("vid_data", vid_data, ve.data);
            chk("vid_latency", cyc, ve.due);
          end
        end
        if (cpu_ack) begin
          chk("cpu_ack_expected", 32'(cpu_q.size() != 0), 1);
          if (cpu_q.size() != 0) begin
            ce = cpu_q.pop_front();
            if (ce.chk) chk("cpu_dout", cpu_dout, ce.dout);
          end
        end
        if (mem_we) begin
          wr_cnt++;
          last_wa = mem_addr;
          last_wd = mem_wdata;
        end
      end
    end
  end

  task automatic vid_fetch(input logic [13:0] a, input logic [15:0] d);
    @(negedge clk_sys);
    vid_req  = 1'b1;
    vid_addr = a;
    vid_q.push_back('{data: d, due: cyc + 4});
    @(negedge clk_sys);
    vid_req = 1'b0;
  endtask

  // Holds cpu_req for one clock past the ack, then drops it.
  task automatic cpu_op(input logic we, input logic [15:0] a, input logic [7:0] din,
                        input logic [7:0] col, input logic [7:0] exp_dout,
                        input int min_lat, input int max_lat);
    int start, lat;
    logic got;
    @(negedge clk_sys);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = din; cpu_color = col;
    cpu_q.push_back('{chk: ~we, dout: exp_dout});
    start = cyc;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_sys);
      if (cpu_ack) got = 1'b1;
    end
    lat = cyc - start - 1;
    chk("cpu_ack_seen", 32'(got), 1);
    chk("cpu_latency_ok", 32'(lat >= min_lat && lat <= max_lat), 1);
    @(negedge clk_sys);
    cpu_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, n, bad;
    logic seen;
    reset = 1'b1; vid_req = 1'b0; vid_addr = '0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_din = '0; cpu_color = '0; fill_start = 1'b0; fill_color = '0;
    repeat (3) @(negedge clk_sys);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_vid_valid", vid_valid, 0);
    chk("rst_vid_data", vid_data, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_cpu_dout", cpu_dout, 0);
    chk("rst_fill_busy", fill_busy, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);

    // Preload word 5 through the CPU path.
    cpu_op(1'b1, 16'h9005, 8'hA5, 8'h4A, 8'h00, 3, 3);
    repeat (2) @(negedge clk_sys);
    chk("preload_word5", vram[5], 16'h4AA5);

    w0 = wr_cnt;
    cpu_op(1'b1, 16'h9003, 8'h81, 8'h20, 8'h00, 3, 3);
    chk("cpu_wr_addr", last_wa, 14'h0003);
    chk("cpu_wr_data", last_wd, 16'h2081);
    repeat (3) @(negedge clk_sys);
    chk("cpu_wr_single", wr_cnt - w0, 1);

    vid_fetch(14'h0005, 16'h4AA5);
    repeat (5) @(negedge clk_sys);
    chk("vid_q_drained", vid_q.size(), 0);

    w0 = wr_cnt;
    cpu_op(1'b0, 16'h4000, 8'h00, 8'h00, 8'hFF, 1, 1);
    repeat (3) @(negedge clk_sys);
    chk("oow_no_write", wr_cnt - w0, 0);

    cpu_op(1'b0, 16'h9005, 8'h00, 8'h00, 8'hA5, 3, 3);

    // Video every other clock alongside back-to-back CPU reads.
    fork
      begin
        for (int i = 0; i < 8; i++)
          vid_fetch(i[0] ? 14'd3 : 14'd5, i[0] ? 16'h2081 : 16'h4AA5);
      end
      begin
        for (int j = 0; j < 4; j++)
          cpu_op(1'b0, j[0] ? 16'h9005 : 16'h9003, 8'h00, 8'h00, j[0] ? 8'hA5 : 8'h81, 3, 4);
      end
    join
    repeat (6) @(negedge clk_sys);
    chk("contention_vid_drained", vid_q.size(), 0);
    chk("contention_cpu_drained", cpu_q.size(), 0);

    // Full-screen fill with a second start mid-way that must be ignored.
    @(negedge clk_sys);
    fill_start = 1'b1; fill_color = 8'h70;
    @(negedge clk_sys);
    fill_start = 1'b0;
    chk("fill_busy_rise", fill_busy, 1);
    n = 1;
    for (int i = 0; i < 13000; i++) begin
      @(negedge clk_sys);
      fill_start = (n == 5000);
      fill_color = (n == 5000) ? 8'h33 : 8'h70;
      if (!fill_busy) break;
      n++;
    end
    fill_start = 1'b0;
    chk("fill_cycles", n, WORDS);
    chk("fill_busy_fall", fill_busy, 0);
    repeat (2) @(negedge clk_sys);
    bad = 0;
    for (int k = 0; k < int'(WORDS); k++) if (vram[k] !== 16'h7000) bad++;
    chk("fill_bad_words", bad, 0);

    // Reset in the middle of a fill, then restart from address 0.
    @(negedge clk_sys);
    fill_start = 1'b1; fill_color = 8'h11;
    @(negedge clk_sys);
    fill_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk_sys);
      if (mem_we && mem_addr == 14'h0100) seen = 1'b1;
    end
    chk("fill_reached_0100", 32'(seen), 1);
    reset = 1'b1;
    #1;
    chk("midfill_rst_busy", fill_busy, 0);
    chk("midfill_rst_mem_we", mem_we, 0);
    chk("midfill_rst_mem_addr", mem_addr, 0);
    chk("midfill_rst_mem_wdata", mem_wdata, 0);
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    fill_start = 1'b1; fill_color = 8'h22;
    @(negedge clk_sys);
    fill_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (mem_we) seen = 1'b1;
      else @(negedge clk_sys);
    end
    chk("refill_write_seen", 32'(seen), 1);
    chk("refill_first_addr", mem_addr, 14'h0000);
    chk("refill_first_data", mem_wdata, 16'h2200);
    chk("refill_busy", fill_busy, 1);

    repeat (2) @(negedge clk_sys);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
